// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory answering a CPU readM/writeM handshake.
// Ports: clk, reset_n, readM/writeM/address, inout data, inputReady/ackOutput
//   strobes, load_en/load_addr/load_data preload, err flag, num_reads/num_writes.
module mem_responder #(
  parameter int LATENCY   = 2,
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        readM,
  input  logic        writeM,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  output logic        inputReady,
  output logic        ackOutput,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic        err,
  output logic [15:0] num_reads,
  output logic [15:0] num_writes
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_DRIVE, RD_ACK,
    WR_WAIT, WR_ACK, RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_addr;
  logic [15:0]     r_wdata;
  logic [15:0]     r_rd_buf;
  logic            r_is_rd;
  logic            r_err;
  logic [15:0]     r_nrd;
  logic [15:0]     r_nwr;
  logic [15:0]     r_mem [MEM_DEPTH];

  logic            w_cnt_zero;
  logic            w_drop;
  logic            w_drive;
  logic            w_idle;
  logic            w_commit;
  logic            w_unused;

  assign w_cnt_zero = (r_cnt == 4'd0);
  assign w_idle     = (r_state == IDLE);
  assign w_unused   = ^{address[15:AW], load_addr[15:AW]};

  // Active request level fell before the transfer completed.
  assign w_drop =
    ((r_state == RD_WAIT || r_state == RD_DRIVE) && !readM) ||
    ((r_state == WR_WAIT) && !writeM);

  assign w_commit =
    (r_state == WR_WAIT) && writeM && w_cnt_zero;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (readM)       w_next = RD_WAIT;
        else if (writeM) w_next = WR_WAIT;
      end
      RD_WAIT: begin
        if (!readM)          w_next = IDLE;
        else if (w_cnt_zero) w_next = RD_DRIVE;
      end
      RD_DRIVE: begin
        if (!readM) w_next = IDLE;
        else        w_next = RD_ACK;
      end
      RD_ACK:  w_next = RELEASE;
      WR_WAIT: begin
        if (!writeM)         w_next = IDLE;
        else if (w_cnt_zero) w_next = WR_ACK;
      end
      WR_ACK:  w_next = RELEASE;
      RELEASE: begin
        if (!readM && !writeM) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    w_drive    = 1'b0;
    unique case (1'b1)
      (r_state == RD_DRIVE): w_drive = readM;
      (r_state == RD_ACK): begin
        inputReady = 1'b1;
        w_drive    = readM;
      end
      (r_state == WR_ACK):  ackOutput = 1'b1;
      (r_state == RELEASE): w_drive = readM && r_is_rd;
      default: ;
    endcase
  end

  assign data       = w_drive ? r_rd_buf : 'z;
  assign err        = r_err;
  assign num_reads  = r_nrd;
  assign num_writes = r_nwr;

  // Writes wait one extra cycle so ackOutput lines up with
  // inputReady, which trails its data-setup cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd_buf <= '0;
      r_is_rd  <= 1'b0;
      r_err    <= 1'b0;
      r_nrd    <= '0;
      r_nwr    <= '0;
    end else begin
      if (w_idle && (readM || writeM)) begin
        r_addr  <= address[AW-1:0];
        r_is_rd <= readM;
        r_cnt   <= readM ? 4'(LATENCY - 1) : 4'(LATENCY);
        if (!readM) r_wdata <= data;
      end else if ((r_state == RD_WAIT || r_state == WR_WAIT)
                   && !w_cnt_zero) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if ((r_state == RD_WAIT) && readM && w_cnt_zero)
        r_rd_buf <= r_mem[r_addr];
      if ((w_idle && readM && writeM) || w_drop)
        r_err <= 1'b1;
      if (r_state == RD_ACK) r_nrd <= r_nrd + 16'd1;
      if (r_state == WR_ACK) r_nwr <= r_nwr + 16'd1;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_commit)
      r_mem[r_addr] <= r_wdata;
    else if (w_idle && load_en && !readM && !writeM)
      r_mem[load_addr[AW-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table, hand-written and random checks of mem_responder
// against an array model of the memory and its counters.
module tb_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        readM = 1'b0;
  logic        writeM = 1'b0;
  logic        load_en = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] tb_wdata = '0;
  wire  [15:0] data;
  logic        inputReady;
  logic        ackOutput;
  logic        err;
  logic [15:0] num_reads;
  logic [15:0] num_writes;

  // The CPU side owns the bus whenever it is not reading.
  assign data = readM ? 'z : tb_wdata;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(LAT), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .readM(readM), .writeM(writeM),
    .address(address), .data(data),
    .inputReady(inputReady), .ackOutput(ackOutput),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .err(err),
    .num_reads(num_reads), .num_writes(num_writes)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] mdl [DEPTH];
  int  m_rd = 0;
  int  m_wr = 0;
  bit  m_err = 1'b0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_nrd"}, num_reads, 16'(m_rd));
    chk({nm, "_nwr"}, num_writes, 16'(m_wr));
    chk({nm, "_err"}, {15'd0, err}, {15'd0, m_err});
  endtask

  task automatic do_load(input logic [15:0] a,
                         input logic [15:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mdl[a % DEPTH] = d;
  endtask

  task automatic do_read(input logic [15:0] a,
                         input logic [15:0] exp,
                         input bit both, input bit ld,
                         input string nm);
    int first;
    int npulse;
    first = -1; npulse = 0;
    @(negedge clk);
    readM = 1'b1; writeM = both; address = a;
    if (ld) begin
      load_en = 1'b1; load_addr = a; load_data = ~exp;
    end
    for (int j = 0; j <= LAT + 2; j++) begin
      @(negedge clk);
      if (j == 0) begin
        load_en = 1'b0;
        address = ~a;
      end
      if (inputReady) begin
        npulse++;
        if (first < 0) first = j;
      end
      if (j >= LAT) chk({nm, "_data"}, data, exp);
    end
    chk({nm, "_irpos"}, 16'(first), 16'(LAT + 1));
    chk({nm, "_ircnt"}, 16'(npulse), 16'd1);
    readM = 1'b0; writeM = 1'b0; tb_wdata = '0;
    m_rd++;
    if (both) m_err = 1'b1;
    @(negedge clk);
    chk({nm, "_rel"}, data, 16'h0000);
    chk_state(nm);
  endtask

  task automatic do_write(input logic [15:0] a,
                          input logic [15:0] d,
                          input string nm);
    int first;
    int npulse;
    first = -1; npulse = 0;
    @(negedge clk);
    writeM = 1'b1; address = a; tb_wdata = d;
    for (int j = 0; j <= LAT + 2; j++) begin
      @(negedge clk);
      if (j == 0) begin
        address = ~a;
        tb_wdata = ~d;
      end
      if (ackOutput) begin
        npulse++;
        if (first < 0) first = j;
      end
    end
    chk({nm, "_ackpos"}, 16'(first), 16'(LAT + 1));
    chk({nm, "_ackcnt"}, 16'(npulse), 16'd1);
    writeM = 1'b0; tb_wdata = '0;
    mdl[a % DEPTH] = d;
    m_wr++;
    @(negedge clk);
    chk_state(nm);
  endtask

  initial begin
    tbl[0] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b1, 16'h0007, 16'h1234, 16'h0000};
    tbl[2] = '{1'b0, 16'h0007, 16'h0000, 16'h1234};
    tbl[3] = '{1'b0, 16'h0105, 16'h0000, 16'hBEEF};
    tbl[4] = '{1'b1, 16'hFF00, 16'h5A5A, 16'h0000};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A};
    tbl[6] = '{1'b1, 16'h00FF, 16'hFFFF, 16'h0000};
    tbl[7] = '{1'b0, 16'h01FF, 16'h0000, 16'hFFFF};

    #1;
    chk("rst_ir", {15'd0, inputReady}, 16'd0);
    chk("rst_ack", {15'd0, ackOutput}, 16'd0);
    chk_state("rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      do_load(16'(i), 16'($urandom));
    do_load(16'h0005, 16'hBEEF);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].addr, tbl[i].wdata, $sformatf("tbl%0d", i));
      else
        do_read(tbl[i].addr, tbl[i].exp, 1'b0, 1'b0,
                $sformatf("tbl%0d", i));
    end

    // Request beats a simultaneous preload; preload ignored while busy.
    do_read(16'd30, mdl[30], 1'b0, 1'b1, "req_over_load");
    do_read(16'd30, mdl[30], 1'b0, 1'b0, "load_skip");

    for (int i = 0; i < 150; i++) begin
      logic [15:0] a;
      logic [15:0] d;
      a = 16'($urandom);
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, $sformatf("rnd%0d", i));
      else
        do_read(a, mdl[a % DEPTH], 1'b0, 1'b0,
                $sformatf("rnd%0d", i));
    end

    chk_state("pre_err");

    // Read and write together: read wins, word untouched.
    do_read(16'd9, mdl[9], 1'b1, 1'b0, "rw_both");
    do_read(16'd9, mdl[9], 1'b0, 1'b0, "rw_after");

    // Read dropped after one cycle.
    @(negedge clk);
    readM = 1'b1; address = 16'd40;
    @(negedge clk);
    readM = 1'b0;
    m_err = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("drop_ir", {15'd0, inputReady}, 16'd0);
      chk("drop_bus", data, 16'h0000);
    end
    chk_state("drop");
    do_read(16'd40, mdl[40], 1'b0, 1'b0, "drop_next");

    // Write dropped in its wait: no ack, no store.
    @(negedge clk);
    writeM = 1'b1; address = 16'd41; tb_wdata = ~mdl[41];
    @(negedge clk);
    writeM = 1'b0; tb_wdata = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("wdrop_ack", {15'd0, ackOutput}, 16'd0);
    end
    chk_state("wdrop");
    do_read(16'd41, mdl[41], 1'b0, 1'b0, "wdrop_mem");

    // Reset during a pending write.
    @(negedge clk);
    writeM = 1'b1; address = 16'd20; tb_wdata = ~mdl[20];
    @(negedge clk);
    reset_n = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 1'b0;
    #1;
    chk("mrst_ir", {15'd0, inputReady}, 16'd0);
    chk("mrst_ack", {15'd0, ackOutput}, 16'd0);
    chk_state("mrst");
    repeat (3) @(negedge clk);
    writeM = 1'b0; tb_wdata = '0;
    reset_n = 1'b1;
    do_read(16'd20, mdl[20], 1'b0, 1'b0, "mrst_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
